// File: rtl/descrambler.sv
// Lane descrambler: undoes x^58+x^39+1 multiplicative scrambling, reloads the LFSR
// from metaframe state words and tracks metaframe lock from periodic sync words.
module descrambler #(
  parameter int unsigned RX_DATA_WIDTH    = 64,
  parameter logic [63:0] SYNC_WORD        = 64'h78f678f678f678f6,
  parameter int unsigned METAFRAME_LENGTH = 2048,
  parameter int unsigned LOCK_COUNT       = 4,
  parameter int unsigned LOSS_COUNT       = 3
) (
  input  logic                     USER_CLK,
  input  logic                     SYSTEM_RESET_N,
  input  logic                     PASSTHROUGH,
  input  logic [RX_DATA_WIDTH-1:0] SCRAMBLED_DATA_IN,
  input  logic [1:0]               HEADER_IN,
  input  logic                     DATA_IN_VALID,
  output logic [RX_DATA_WIDTH-1:0] DESCRAMBLED_DATA_OUT,
  output logic [1:0]               HEADER_OUT,
  output logic                     DATA_OUT_VALID,
  output logic                     LOCKED,
  output logic                     SYNC_ERR,
  output logic                     SCR_STATE_ERR
);

  localparam int unsigned       LFSR_W     = 58;
  localparam int unsigned       CNT_W      = $clog2(METAFRAME_LENGTH + 1);
  localparam logic [1:0]        HDR_CTRL   = 2'b10;
  localparam logic [5:0]        STATE_TYPE = 6'b001010;
  localparam logic [LFSR_W-1:0] LFSR_SEED  = '1;

  typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} state_e;

  state_e                   state_q, state_d;
  logic [LFSR_W-1:0]        lfsr_q, lfsr_d, lfsr_step;
  logic [CNT_W-1:0]         pos_q, pos_d, good_q, good_d, bad_q, bad_d, pos_next;
  logic                     arm_q, arm_d;
  logic [RX_DATA_WIDTH-1:0] data_q, data_d, descr;
  logic [1:0]               header_q, header_d;
  logic                     valid_q, valid_d, locked_q, locked_d;
  logic                     sync_err_q, sync_err_d, state_err_q, state_err_d;
  logic                     is_sync, type_ok, lfsr_mismatch, at_expected;

  // Bit-serial descramble of the whole word, bit 0 first, scrambled bits fed back.
  always_comb begin
    lfsr_step = lfsr_q;
    descr     = '0;
    for (int i = 0; i < RX_DATA_WIDTH; i++) begin
      descr[i]  = SCRAMBLED_DATA_IN[i] ^ lfsr_step[38] ^ lfsr_step[57];
      lfsr_step = {lfsr_step[LFSR_W-2:0], SCRAMBLED_DATA_IN[i]};
    end
  end

  assign is_sync       = (HEADER_IN == HDR_CTRL) && (SCRAMBLED_DATA_IN == SYNC_WORD);
  assign type_ok       = (SCRAMBLED_DATA_IN[RX_DATA_WIDTH-1 -: 6] == STATE_TYPE);
  assign lfsr_mismatch = (SCRAMBLED_DATA_IN[LFSR_W-1:0] != lfsr_q);
  assign pos_next      = pos_q + CNT_W'(1);
  assign at_expected   = (pos_next == CNT_W'(METAFRAME_LENGTH));

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    pos_d       = pos_q;
    good_d      = good_q;
    bad_d       = bad_q;
    arm_d       = arm_q;
    data_d      = data_q;
    header_d    = HEADER_IN;
    valid_d     = DATA_IN_VALID;
    sync_err_d  = 1'b0;
    state_err_d = 1'b0;

    if (PASSTHROUGH) begin
      if (DATA_IN_VALID) begin
        data_d = SCRAMBLED_DATA_IN;
      end
      state_d = ST_HUNT;
      lfsr_d  = LFSR_SEED;
      pos_d   = '0;
      good_d  = '0;
      bad_d   = '0;
      arm_d   = 1'b0;
    end else if (DATA_IN_VALID) begin
      // Sync and state words carry no scrambled payload; only data words advance the LFSR.
      if (is_sync) begin
        data_d = SCRAMBLED_DATA_IN;
        arm_d  = 1'b1;
      end else if (arm_q) begin
        data_d = SCRAMBLED_DATA_IN;
        arm_d  = 1'b0;
        if (type_ok) begin
          lfsr_d      = SCRAMBLED_DATA_IN[LFSR_W-1:0];
          state_err_d = (state_q == ST_LOCKED) && lfsr_mismatch;
        end else begin
          state_err_d = 1'b1;
        end
      end else begin
        data_d = descr;
        lfsr_d = lfsr_step;
      end

      case (state_q)
        ST_HUNT: begin
          if (is_sync) begin
            state_d = ST_VERIFY;
            good_d  = CNT_W'(1);
            pos_d   = '0;
            bad_d   = '0;
          end
        end
        ST_VERIFY: begin
          if (is_sync) begin
            pos_d = '0;
            if (at_expected) begin
              good_d = good_q + CNT_W'(1);
              if (good_d >= CNT_W'(LOCK_COUNT)) begin
                state_d = ST_LOCKED;
                bad_d   = '0;
              end
            end else begin
              good_d = CNT_W'(1);
            end
          end else if (at_expected) begin
            sync_err_d = 1'b1;
            state_d    = ST_HUNT;
            pos_d      = '0;
            good_d     = '0;
          end else begin
            pos_d = pos_next;
          end
        end
        ST_LOCKED: begin
          // Only the expected slot is checked; stray syncs just ride along with pos.
          pos_d = at_expected ? '0 : pos_next;
          if (at_expected && is_sync) begin
            bad_d = '0;
          end
          if (at_expected && !is_sync) begin
            sync_err_d = 1'b1;
          end
          if (sync_err_d || state_err_d) begin
            bad_d = bad_q + CNT_W'(1);
          end
          if (bad_d >= CNT_W'(LOSS_COUNT)) begin
            state_d = ST_HUNT;
            pos_d   = '0;
            good_d  = '0;
            bad_d   = '0;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge USER_CLK) begin
    if (!SYSTEM_RESET_N) begin
      state_q     <= ST_HUNT;
      lfsr_q      <= LFSR_SEED;
      pos_q       <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      arm_q       <= 1'b0;
      data_q      <= '0;
      header_q    <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
      state_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      pos_q       <= pos_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      arm_q       <= arm_d;
      data_q      <= data_d;
      header_q    <= header_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      sync_err_q  <= sync_err_d;
      state_err_q <= state_err_d;
    end
  end

  assign DESCRAMBLED_DATA_OUT = data_q;
  assign HEADER_OUT           = header_q;
  assign DATA_OUT_VALID       = valid_q;
  assign LOCKED               = locked_q;
  assign SYNC_ERR             = sync_err_q;
  assign SCR_STATE_ERR        = state_err_q;

endmodule
